// File: rtl/param_bus_ram_pkg.sv
// Shared definitions for the parametrised bus RAM: fill-sequencer states,
// control-register bit positions and supported read latencies.
package param_bus_ram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    localparam int unsigned CTRL_WP    = 0;
    localparam int unsigned CTRL_CLR   = 1;
    localparam int unsigned CTRL_BUSY  = 2;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/bus_ram_array.sv
// Synchronous RAM: one write port (bus or fill sequencer, muxed by the top)
// and a registered read that returns the word as it was before a same-edge write.
module bus_ram_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 7
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_bus_ram.sv
// Bus-mapped data RAM with configurable window, 1/2-cycle read latency,
// write-protect control register and a hardware fill sequencer.
module param_bus_ram
    import param_bus_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 8,
    parameter int unsigned           DEPTH_LOG2     = 7,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR      = ADDR_WIDTH'(8'hF0),
    parameter int unsigned           READ_LATENCY   = 1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [DATA_WIDTH-1:0] BUS_DATA,
    input  logic [ADDR_WIDTH-1:0] BUS_ADDR,
    input  logic                  BUS_WE,
    output logic                  BUSY
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(DEPTH);

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("param_bus_ram: READ_LATENCY must be 1 or 2");
    end
    if (int'(BASE_ADDR) + int'(DEPTH) > (1 << ADDR_WIDTH)) begin : g_bad_window
        $error("param_bus_ram: memory window exceeds address space");
    end
    if (CTRL_ADDR >= BASE_ADDR && int'(CTRL_ADDR) < int'(BASE_ADDR) + int'(DEPTH)) begin : g_bad_ctrl
        $error("param_bus_ram: CTRL_ADDR lies inside the memory window");
    end
    if (DATA_WIDTH < 3) begin : g_bad_width
        $error("param_bus_ram: DATA_WIDTH too small for control register");
    end

    fill_state_e            state_q;
    logic [DEPTH_LOG2-1:0]  cnt_q;
    logic                   wp_q;

    logic                   mem_sel, ctrl_sel, bus_wr, ctrl_wr, rd_req;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [DATA_WIDTH-1:0]  ctrl_rd, ram_rdata, rd1_data;
    logic                   rd1_en_q, rd1_ctrl_q;
    logic [DATA_WIDTH-1:0]  rd1_ctrl_val_q;
    logic                   drv_en;
    logic [DATA_WIDTH-1:0]  drv_data;

    assign mem_sel  = ({1'b0, BUS_ADDR} >= WIN_LO) && ({1'b0, BUS_ADDR} < WIN_HI);
    assign ctrl_sel = (BUS_ADDR == CTRL_ADDR);
    assign idx      = DEPTH_LOG2'(BUS_ADDR - BASE_ADDR);
    assign BUSY     = (state_q == ST_FILL);

    assign bus_wr   = BUS_WE & mem_sel & ~wp_q & ~BUSY;
    assign ctrl_wr  = BUS_WE & ctrl_sel;
    assign rd_req   = ~BUS_WE & (ctrl_sel | (mem_sel & ~BUSY));

    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[CTRL_WP]   = wp_q;
        ctrl_rd[CTRL_BUSY] = BUSY;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= CLEAR_ON_RESET ? ST_FILL : ST_IDLE;
            cnt_q   <= '0;
            wp_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                wp_q <= BUS_DATA[CTRL_WP];
            end
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_wr && BUS_DATA[CTRL_CLR]) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt_q <= cnt_q + DEPTH_LOG2'(1);
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bus_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (BUSY | bus_wr),
        .waddr_i (BUSY ? cnt_q : idx),
        .wdata_i (BUSY ? FILL_VALUE : BUS_DATA),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    // CTRL reads are snapshotted alongside the RAM's registered read so both
    // sources share the same first pipeline stage.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd1_en_q       <= 1'b0;
            rd1_ctrl_q     <= 1'b0;
            rd1_ctrl_val_q <= '0;
        end else begin
            rd1_en_q       <= rd_req;
            rd1_ctrl_q     <= ctrl_sel;
            rd1_ctrl_val_q <= ctrl_rd;
        end
    end

    assign rd1_data = rd1_ctrl_q ? rd1_ctrl_val_q : ram_rdata;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  rd2_en_q;
        logic [DATA_WIDTH-1:0] rd2_data_q;
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                rd2_en_q   <= 1'b0;
                rd2_data_q <= '0;
            end else begin
                rd2_en_q   <= rd1_en_q & ~BUS_WE;
                rd2_data_q <= rd1_data;
            end
        end
        assign drv_en   = rd2_en_q;
        assign drv_data = rd2_data_q;
    end else begin : g_lat1
        assign drv_en   = rd1_en_q;
        assign drv_data = rd1_data;
    end

    // Never contend with the CPU: a write cycle suppresses the drive outright.
    assign BUS_DATA = (drv_en & ~BUS_WE) ? drv_data : 'z;

endmodule

// File: tb/tb_param_bus_ram.sv
// Bench for param_bus_ram: a LAT=1/base 0x00 instance and a LAT=2/base 0x40
// instance share one stimulus stream and are checked against a behavioural model.
module tb_param_bus_ram;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr  = 8'hE0;
    logic       we    = 1'b0;
    logic [7:0] wdat  = 8'h00;
    logic       busy_a, busy_b;
    tri1  [7:0] bus_a, bus_b;

    int total = 0;
    int bad   = 0;

    int         fill_left [2];
    logic [7:0] mem       [2][128];
    bit         wp        [2];
    bit         pv        [2][2];
    logic [7:0] pd        [2][2];

    assign bus_a = we ? wdat : 8'bz;
    assign bus_b = we ? wdat : 8'bz;

    always #5 clk = ~clk;

    param_bus_ram #(
        .READ_LATENCY   (1),
        .BASE_ADDR      (8'h00),
        .CLEAR_ON_RESET (1'b1)
    ) dut_a (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_DATA (bus_a),
        .BUS_ADDR (addr),
        .BUS_WE   (we),
        .BUSY     (busy_a)
    );

    param_bus_ram #(
        .READ_LATENCY   (2),
        .BASE_ADDR      (8'h40),
        .CLEAR_ON_RESET (1'b1)
    ) dut_b (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_DATA (bus_b),
        .BUS_ADDR (addr),
        .BUS_WE   (we),
        .BUSY     (busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            fill_left[d] = 128;
            wp[d]        = 1'b0;
            pv[d][0]     = 1'b0;
            pv[d][1]     = 1'b0;
        end
    endtask

    // Instance d has read latency d+1 and its window at 64*d .. 64*d+127.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit         busy, in_win, rd, start;
            int         a, b, idx;
            logic [7:0] val;
            busy   = fill_left[d] > 0;
            a      = int'(addr);
            b      = 64 * d;
            in_win = (a >= b) && (a < b + 128);
            idx    = in_win ? a - b : 0;
            rd     = !we && (a == 240 || (in_win && !busy));
            val    = (a == 240) ? {5'b0, busy, 1'b0, wp[d]} : mem[d][idx];
            start  = 1'b0;
            if (we && in_win && !wp[d] && !busy) mem[d][idx] = wdat;
            if (we && a == 240) begin
                wp[d] = wdat[0];
                start = wdat[1] && !busy;
            end
            if (busy) begin
                mem[d][128 - fill_left[d]] = 8'h00;
                fill_left[d]--;
            end
            if (start) fill_left[d] = 128;
            pv[d][1] = pv[d][0];
            pd[d][1] = pd[d][0];
            pv[d][0] = rd;
            pd[d][0] = val;
        end
    endtask

    initial begin : model
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 128; i++) mem[d][i] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("busy_a", {31'b0, busy_a}, {31'b0, fill_left[0] > 0});
            chk("busy_b", {31'b0, busy_b}, {31'b0, fill_left[1] > 0});
            if (!we) begin
                chk("bus_a", {24'b0, bus_a}, {24'b0, pv[0][0] ? pd[0][0] : 8'hFF});
                chk("bus_b", {24'b0, bus_b}, {24'b0, pv[1][1] ? pd[1][1] : 8'hFF});
            end
        end
    end

    task automatic step(input logic [7:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #2;
        addr = a;
        we   = w;
        wdat = d;
    endtask

    task automatic idle();
        step(8'hE0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(a, 1'b1, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(a, 1'b0, 8'h00);
    endtask

    task automatic wait_fill(output int na, output int nb);
        int n;
        n  = 0;
        na = 0;
        nb = 0;
        while ((busy_a || busy_b) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy_a && na == 0) na = n;
            if (!busy_b && nb == 0) nb = n;
        end
    endtask

    initial begin : stimulus
        int na, nb, cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", {31'b0, busy_a}, 32'd1);
        chk("rst_float_a", {24'b0, bus_a}, 32'hFF);
        #1 rst_n = 1'b1;
        wait_fill(na, nb);
        chk("fill_len_a", na, 32'd128);
        chk("fill_len_b", nb, 32'd128);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ai;
            ai = 8'(i);
            rd(ai);
        end
        idle();
        idle();

        wr(8'h10, 8'h5A);
        rd(8'h10);
        idle();
        @(negedge clk) chk("lat1_rd_5a", {24'b0, bus_a}, 32'h5A);
        wr(8'h40, 8'hC3);
        rd(8'h40);
        idle();
        @(negedge clk);
        chk("a_c3", {24'b0, bus_a}, 32'hC3);
        chk("b_not_yet", {24'b0, bus_b}, 32'hFF);
        idle();
        @(negedge clk);
        chk("lat2_c3", {24'b0, bus_b}, 32'hC3);
        chk("a_hiz_after", {24'b0, bus_a}, 32'hFF);

        wr(8'hF0, 8'h01);
        wr(8'h10, 8'hFF);
        rd(8'h10);
        idle();
        @(negedge clk) chk("wp_blocks", {24'b0, bus_a}, 32'h5A);
        rd(8'hF0);
        idle();
        @(negedge clk) chk("ctrl_wp_rd", {24'b0, bus_a}, 32'h01);
        wr(8'hF0, 8'h00);
        wr(8'h10, 8'h77);
        rd(8'h10);
        idle();
        @(negedge clk) chk("wp_cleared", {24'b0, bus_a}, 32'h77);

        wr(8'hF0, 8'h02);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            case (i)
                3:       wr(8'h20, 8'h33);
                5:       rd(8'h20);
                7:       rd(8'hF0);
                20:      wr(8'hF0, 8'h02);
                default: idle();
            endcase
            @(negedge clk);
            if (i == 6) chk("fill_rd_float", {24'b0, bus_a}, 32'hFF);
            if (i == 8) chk("ctrl_busy_rd", {24'b0, bus_a}, 32'h04);
            if (busy_a) cnt++;
            else break;
        end
        chk("clr_fill_len", cnt, 32'd128);
        wait_fill(na, nb);
        rd(8'h20);
        idle();
        @(negedge clk) chk("fill_cleared_20", {24'b0, bus_a}, 32'h00);

        wr(8'hF0, 8'h02);
        for (int i = 0; i < 50; i++) begin
            if (i == 49) rd(8'hF0);
            else         idle();
        end
        @(posedge clk);
        #1;
        chk("pre_rst_drive", {24'b0, bus_a}, 32'h04);
        addr = 8'hE0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hiz_a", {24'b0, bus_a}, 32'hFF);
        chk("rst_busy_mid", {31'b0, busy_a}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_fill(na, nb);
        chk("refill_len_a", na, 32'd128);

        wr(8'hC0, 8'h22);
        wr(8'h3F, 8'h11);
        rd(8'h40);
        idle();
        idle();
        @(negedge clk) chk("b_word0_clean", {24'b0, bus_b}, 32'h00);
        rd(8'h3F);
        idle();
        idle();
        @(negedge clk) chk("b_below_float", {24'b0, bus_b}, 32'hFF);
        rd(8'hC0);
        idle();
        idle();
        @(negedge clk) chk("b_above_float", {24'b0, bus_b}, 32'hFF);
        wr(8'h40, 8'h44);
        wr(8'hBF, 8'h55);
        rd(8'hBF);
        idle();
        idle();
        @(negedge clk) chk("b_bf_word127", {24'b0, bus_b}, 32'h55);
        rd(8'h40);
        idle();
        idle();
        @(negedge clk) chk("b_40_word0", {24'b0, bus_b}, 32'h44);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
